bram_stream_reader: RTL and testbench

- Read-side master for the 32x4 synchronous single-port BRAM, complementing the sequential address-sweep write path.
- On a start request it reads a contiguous run of words (with address wrap) and presents them as a valid/ready stream to a downstream consumer.
- Absorbs the BRAM's one-cycle read latency and downstream backpressure with a 2-entry output buffer, sustaining one word per cycle.

---
 rtl/bram_stream_reader_if.sv | 29 ++
 rtl/bram_stream_reader.sv | 118 +++++++++++
 tb/tb_bram_stream_reader.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/bram_stream_reader_if.sv
// Bundle between the burst reader, its BRAM read port, its controller and its
// stream consumer. The master modport is the reader's own view.
interface bram_stream_reader_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 4
);
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W:0]   length;
   logic              bram_we;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_rdata;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              busy;
   logic              done;

   modport master (
      input  start, base_addr, length, bram_rdata, out_ready,
      output bram_we, bram_addr, out_valid, out_data, out_last, busy, done
   );

   modport slave (
      output start, base_addr, length, bram_rdata, out_ready,
      input  bram_we, bram_addr, out_valid, out_data, out_last, busy, done
   );
endinterface

// File: rtl/bram_stream_reader.sv
// Reads a contiguous (wrapping) run of BRAM words and streams them out,
// hiding the one-cycle read latency behind a 2-entry output buffer.
module bram_stream_reader #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 4,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic                        clk,
   input  logic                        rst_n,
   bram_stream_reader_if.master        bus,
   output logic [1:0]                  o_dbg_state
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2} state_t;

   localparam logic [ADDR_W:0]   CNT_ONE  = 1;
   localparam logic [ADDR_W-1:0] ADDR_TOP = ADDR_W'(DEPTH - 1);

   state_t            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W:0]   r_issue_cnt, r_out_cnt;
   logic              r_pending, r_done;
   logic [DATA_W-1:0] r_buf0, r_buf1;
   logic [1:0]        r_count;
   logic              w_start_go, w_start_zero, w_pop, w_push, w_issue, w_last_pop, w_busy;
   logic [2:0]        w_occ;

   // Stream handshake: a word transfers on a rising edge where out_valid and
   // out_ready are both 1; once raised, out_valid/out_data/out_last hold until then.
   assign w_start_go   = (r_state == S_IDLE) && bus.start && (bus.length != '0);
   assign w_start_zero = (r_state == S_IDLE) && bus.start && (bus.length == '0);
   assign w_pop        = (r_count != 2'd0) && bus.out_ready;
   assign w_push       = r_pending;
   assign w_occ        = {1'b0, r_count} + {2'b00, r_pending} - {2'b00, w_pop};
   assign w_issue      = (r_state == S_RUN) && (r_issue_cnt != '0) && (w_occ < 3'd2);
   assign w_last_pop   = w_pop && (r_out_cnt == CNT_ONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (w_start_go) w_state_nxt = S_RUN;
         S_RUN:   if (w_issue && (r_issue_cnt == CNT_ONE)) w_state_nxt = S_FLUSH;
         S_FLUSH: if (w_last_pop) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_busy      = (r_state != S_IDLE);
      o_dbg_state = r_state;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr      <= '0;
         r_issue_cnt <= '0;
         r_out_cnt   <= '0;
         r_pending   <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done    <= w_start_zero || ((r_state == S_FLUSH) && w_last_pop);
         r_pending <= w_issue;
         if (w_start_go) begin
            r_addr      <= bus.base_addr;
            r_issue_cnt <= bus.length;
         end else if (w_issue) begin
            r_addr      <= (r_addr == ADDR_TOP) ? '0 : r_addr + 1'b1;
            r_issue_cnt <= r_issue_cnt - 1'b1;
         end
         if (w_start_go)  r_out_cnt <= bus.length;
         else if (w_pop)  r_out_cnt <= r_out_cnt - 1'b1;
      end
   end

   // Head entry lives in r_buf0 so the stream outputs come straight from a register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buf0  <= '0;
         r_buf1  <= '0;
         r_count <= 2'd0;
      end else begin
         unique case ({w_push, w_pop})
            2'b10: begin
               if (r_count == 2'd0) r_buf0 <= bus.bram_rdata;
               else                 r_buf1 <= bus.bram_rdata;
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               r_buf0  <= r_buf1;
               r_count <= r_count - 2'd1;
            end
            2'b11: begin
               if (r_count == 2'd1) r_buf0 <= bus.bram_rdata;
               else begin
                  r_buf0 <= r_buf1;
                  r_buf1 <= bus.bram_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(w_push && !w_pop && (r_count == 2'd2)));

   assign bus.bram_we   = 1'b0;
   assign bus.bram_addr = r_addr;
   assign bus.out_valid = (r_count != 2'd0);
   assign bus.out_data  = r_buf0;
   assign bus.out_last  = (r_count != 2'd0) && (r_out_cnt == CNT_ONE);
   assign bus.busy      = w_busy;
   assign bus.done      = r_done;
endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: BRAM model, vector table, random bursts and
// hand-written reset/abort sequences, all scored against a queue-based model.
module tb_bram_stream_reader;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] dbg_state;
   logic [3:0] mem [32];
   logic [4:0] exp_q [$];
   int         n_tests = 0;
   int         n_fail = 0;

   bram_stream_reader_if #(.ADDR_W(5), .DATA_W(4)) bus ();

   bram_stream_reader #(.ADDR_W(5), .DATA_W(4), .DEPTH(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus.master),
      .o_dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   // Synchronous single-port BRAM, read side only.
   always @(posedge clk) bus.bram_rdata <= mem[bus.bram_addr];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [4:0] base;
      logic [5:0] len;
      logic [7:0] pat;
      int         mid_start;
      logic [3:0] exp_first;
      logic [3:0] exp_lastd;
   } vec_t;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic fill_mem(input bit rnd);
      for (int i = 0; i < 32; i++) mem[i] = rnd ? 4'($urandom_range(0, 15)) : 4'(i % 16);
   endtask

   task automatic run_burst(input logic [4:0] base, input logic [5:0] len, input logic [7:0] pat,
                            input int mid_start, output logic [3:0] first_d, output logic [3:0] last_d);
      int first_k, first_pop_k, last_pop_k, n_pop, done_cnt, done_k;
      logic prev_stall, prev_last;
      logic [3:0] prev_data;
      logic [4:0] e;
      first_d = '0; last_d = '0;
      exp_q.delete();
      for (int i = 0; i < int'(len); i++)
         exp_q.push_back({(i == int'(len) - 1), mem[(int'(base) + i) % 32]});
      @(negedge clk);
      bus.start = 1'b1; bus.base_addr = base; bus.length = len; bus.out_ready = pat[0];
      @(negedge clk);
      bus.start = 1'b0;
      if (len != 0) begin
         check("addr_after_start", 32'(bus.bram_addr), 32'(base));
         check("busy_after_start", 32'(bus.busy), 1);
      end
      first_k = -1; first_pop_k = -1; last_pop_k = -1; n_pop = 0; done_cnt = 0; done_k = -1;
      prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
      for (int k = 0; k < 400; k++) begin
         if (k > 0) @(negedge clk);
         if (k == mid_start && k > 0) begin
            bus.start = 1'b1; bus.base_addr = 5'd0; bus.length = 6'd3;
         end else bus.start = 1'b0;
         bus.out_ready = pat[k % 8];
         check("bram_we_low", 32'(bus.bram_we), 0);
         if (prev_stall) begin
            check("stall_valid", 32'(bus.out_valid), 1);
            check("stall_data", 32'(bus.out_data), 32'(prev_data));
            check("stall_last", 32'(bus.out_last), 32'(prev_last));
         end
         if (bus.done) begin
            done_cnt++;
            if (done_k < 0) done_k = k;
            check("busy_at_done", 32'(bus.busy), 0);
         end else if (done_k < 0 && len != 0) check("busy_in_burst", 32'(bus.busy), 1);
         if (bus.out_valid) begin
            if (first_k < 0) first_k = k;
            if (bus.out_ready) begin
               if (exp_q.size() == 0) check("extra_word", 32'(bus.out_data), 32'hFFFF);
               else begin
                  e = exp_q.pop_front();
                  check("word_last_data", {27'd0, bus.out_last, bus.out_data}, {27'd0, e});
               end
               if (n_pop == 0) begin first_d = bus.out_data; first_pop_k = k; end
               if (bus.out_last) last_d = bus.out_data;
               last_pop_k = k;
               n_pop++;
            end
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_data  = bus.out_data;
         prev_last  = bus.out_last;
         if (done_k >= 0 && k >= done_k + 3) break;
      end
      if (done_k < 0) check("done_timeout", 0, 1);
      check("done_count", 32'(done_cnt), 1);
      check("words_left", 32'(exp_q.size()), 0);
      if (len != 0) check("first_valid_latency", 32'(first_k), 2);
      else begin
         check("zero_len_valid", 32'(first_k), 32'(-1));
         check("zero_len_done_at", 32'(done_k), 0);
      end
      if (pat == 8'hff && len != 0) check("throughput", 32'(last_pop_k - first_pop_k), 32'(int'(len) - 1));
   endtask

   initial begin
      vec_t vecs [6];
      logic [3:0] fd, ld;
      int n;
      vecs[0] = '{5'd3,  6'd5,  8'hff, -1, 4'd3,  4'd7};
      vecs[1] = '{5'd30, 6'd4,  8'hff, -1, 4'd14, 4'd1};
      vecs[2] = '{5'd0,  6'd6,  8'he9, -1, 4'd0,  4'd5};
      vecs[3] = '{5'd9,  6'd0,  8'hff, -1, 4'd0,  4'd0};
      vecs[4] = '{5'd10, 6'd7,  8'hff,  3, 4'd10, 4'd0};
      vecs[5] = '{5'd17, 6'd32, 8'hb5, -1, 4'd1,  4'd0};

      bus.start = 1'b0; bus.base_addr = '0; bus.length = '0; bus.out_ready = 1'b0;
      fill_mem(1'b0);
      #12;
      check("rst_valid", 32'(bus.out_valid), 0);
      check("rst_last", 32'(bus.out_last), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_done", 32'(bus.done), 0);
      check("rst_addr", 32'(bus.bram_addr), 0);
      check("rst_state", 32'(dbg_state), 0);
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 6; v++) begin
         run_burst(vecs[v].base, vecs[v].len, vecs[v].pat, vecs[v].mid_start, fd, ld);
         if (vecs[v].len != 0) begin
            check($sformatf("vec%0d_first", v), 32'(fd), 32'(vecs[v].exp_first));
            check($sformatf("vec%0d_lastd", v), 32'(ld), 32'(vecs[v].exp_lastd));
         end
      end

      // Reset asserted right after the second word is accepted.
      @(negedge clk);
      bus.start = 1'b1; bus.base_addr = 5'd4; bus.length = 6'd8; bus.out_ready = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n = 0;
      for (int k = 0; k < 50 && n < 2; k++) begin
         if (bus.out_valid && bus.out_ready) n++;
         if (n < 2) @(negedge clk);
      end
      check("pops_before_reset", 32'(n), 2);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("abort_valid", 32'(bus.out_valid), 0);
      check("abort_last", 32'(bus.out_last), 0);
      check("abort_busy", 32'(bus.busy), 0);
      check("abort_addr", 32'(bus.bram_addr), 0);
      check("abort_state", 32'(dbg_state), 0);
      repeat (2) begin @(negedge clk); check("abort_done_low", 32'(bus.done), 0); end
      rst_n = 1'b1;
      repeat (3) begin @(negedge clk); check("post_abort_done_low", 32'(bus.done), 0); end
      run_burst(5'd4, 6'd8, 8'hff, -1, fd, ld);
      check("post_abort_first", 32'(fd), 4);
      check("post_abort_lastd", 32'(ld), 11);

      for (int r = 0; r < 15; r++) begin
         fill_mem(1'b1);
         run_burst(5'($urandom_range(0, 31)), 6'($urandom_range(0, 32)),
                   8'($urandom_range(0, 255)) | 8'h01, -1, fd, ld);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
